// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: input FIFO, 29-tap complex sample delay line and the
// three-pass control strobes that sequence the FIR datapath accumulator.

package fir_sample_feeder_pkg;
  localparam int DATA_W = 24;
  localparam int TAPS   = 29;

  typedef struct packed {
    logic signed [DATA_W-1:0] I;
    logic signed [DATA_W-1:0] Q;
  } samp_t;
endpackage

module fir_sample_feeder
  import fir_sample_feeder_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ACC_DLY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     PushIn,
  input  logic signed [DATA_W-1:0] SampI,
  input  logic signed [DATA_W-1:0] SampQ,
  output logic                     StopIn,
  output samp_t [TAPS-1:0]         samp,
  output logic [1:0]               mux_sel,
  output logic                     partialProductAccumulate_valid,
  output logic                     finalAccumulateRounding_en
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS0 = 2'd1,
    PASS1 = 2'd2,
    PASS2 = 2'd3
  } state_t;

  samp_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic          fifo_empty;

  state_t        state;
  state_t        state_nxt;
  logic          is_pass12;
  logic          is_pass2;
  logic [ACC_DLY:0] pass2_dly;

  // A push while full is dropped; StopIn comes straight off the registered count.
  assign StopIn     = (count == (AW+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = PushIn & ~StopIn;

  // Stage: FIFO storage write (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{I: SampI, Q: SampQ};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Pass sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pass sequencer: pop on entry to PASS0, one mux_sel value per pass
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    mux_sel   = 2'd0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = PASS0;
        end
      end
      PASS0: begin
        state_nxt = PASS1;
      end
      PASS1: begin
        mux_sel   = 2'd1;
        state_nxt = PASS2;
      end
      PASS2: begin
        mux_sel = 2'd2;
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = PASS0;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stage: delay line, shifts only on a pop so taps hold for all three passes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp <= '0;
    end else if (pop) begin
      samp <= {samp[TAPS-2:0], mem[rd_ptr]};
    end
  end

  assign is_pass12 = (state == PASS1) || (state == PASS2);
  assign is_pass2  = (state == PASS2);

  // Accumulate-valid tap: pass12 term lined up with the datapath accumulator input
  generate
    if (ACC_DLY == 0) begin : g_vld_nodly
      assign partialProductAccumulate_valid = is_pass12;
    end else begin : g_vld_dly
      logic [ACC_DLY-1:0] pass12_dly;

      // Stage: pass12 control pipe, cleared by reset so no stale accumulate survives
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pass12_dly <= '0;
        end else begin
          pass12_dly[0] <= is_pass12;
          for (int k = 1; k < ACC_DLY; k++) begin
            pass12_dly[k] <= pass12_dly[k-1];
          end
        end
      end

      assign partialProductAccumulate_valid = pass12_dly[ACC_DLY-1];
    end
  endgenerate

  // Stage: pass2 control pipe, one cycle longer so the final strobe follows the last accumulate
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass2_dly <= '0;
    end else begin
      pass2_dly[0] <= is_pass2;
      for (int k = 1; k <= ACC_DLY; k++) begin
        pass2_dly[k] <= pass2_dly[k-1];
      end
    end
  end

  assign finalAccumulateRounding_en = pass2_dly[ACC_DLY];

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Self-checking bench for fir_sample_feeder: table-driven timing vectors,
// a sample scoreboard checked at every PASS2 and hand-written corner cases.

module tb_fir_sample_feeder;
  import fir_sample_feeder_pkg::*;

  localparam int DEPTH   = 4;
  localparam int ACC_DLY = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     PushIn;
  logic signed [DATA_W-1:0] SampI;
  logic signed [DATA_W-1:0] SampQ;
  logic                     StopIn;
  samp_t [TAPS-1:0]         samp;
  logic [1:0]               mux_sel;
  logic                     vld;
  logic                     fin;

  fir_sample_feeder #(.DEPTH(DEPTH), .ACC_DLY(ACC_DLY)) dut (
    .clk                            (clk),
    .reset                          (reset),
    .PushIn                         (PushIn),
    .SampI                          (SampI),
    .SampQ                          (SampQ),
    .StopIn                         (StopIn),
    .samp                           (samp),
    .mux_sel                        (mux_sel),
    .partialProductAccumulate_valid (vld),
    .finalAccumulateRounding_en     (fin)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       push;
    logic [1:0] mux;
    logic       vld;
    logic       fin;
    logic       stop;
    logic       newv;
  } vec_t;

  vec_t        tbl [8];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [47:0] sb_q [$];
  int          fin_exp_q [$];
  int          fin_log [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic signed [DATA_W-1:0] i, input logic signed [DATA_W-1:0] q);
    int w;
    w = 0;
    while (StopIn && w < 100) begin
      tick();
      w++;
    end
    if (w >= 100) chk("push_wait_timeout", 1, 0);
    PushIn = 1'b1;
    SampI  = i;
    SampQ  = q;
    sb_q.push_back({i, q});
    tick();
    PushIn = 1'b0;
  endtask

  // Row r drives inputs before edge r and checks outputs just after edge r.
  task automatic run_table(input logic signed [DATA_W-1:0] i, input logic signed [DATA_W-1:0] q,
                           input logic [47:0] prev, input bit check_hist);
    for (int r = 0; r < 8; r++) begin
      PushIn = tbl[r].push;
      SampI  = i;
      SampQ  = q;
      if (tbl[r].push) sb_q.push_back({i, q});
      tick();
      PushIn = 1'b0;
      chk($sformatf("tbl%0d_mux_sel", r), mux_sel, tbl[r].mux);
      chk($sformatf("tbl%0d_acc_valid", r), vld, tbl[r].vld);
      chk($sformatf("tbl%0d_final_en", r), fin, tbl[r].fin);
      chk($sformatf("tbl%0d_stopin", r), StopIn, tbl[r].stop);
      chk($sformatf("tbl%0d_samp0", r), samp[0], tbl[r].newv ? {i, q} : prev);
      if (check_hist && r == 1) chk("tbl_hist_zero", (samp[TAPS-1:1] == '0), 1);
    end
  endtask

  // Monitor: scoreboard on every PASS2 cycle and final-strobe timing.
  initial begin
    logic [47:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb_q.delete();
        fin_exp_q.delete();
      end else begin
        cyc++;
        while (fin_exp_q.size() > 0 && fin_exp_q[0] < cyc) begin
          chk("final_missing", fin_exp_q.pop_front(), 0);
        end
        if (mux_sel == 2'd2) begin
          if (sb_q.size() == 0) begin
            chk("pass2_without_sample", 1, 0);
          end else begin
            e = sb_q.pop_front();
            chk("sb_samp0", samp[0], e);
          end
          fin_exp_q.push_back(cyc + ACC_DLY + 1);
        end
        if (fin) begin
          fin_log.push_back(cyc);
          if (fin_exp_q.size() == 0) chk("unexpected_final", 1, 0);
          else chk("final_time", cyc, fin_exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0]              a_val;
    logic signed [DATA_W-1:0] e24;
    logic [0:7]               stop_exp;
    int                       acc;
    int                       w;
    bit                       any;

    //            push mux   vld  fin  stop newv
    tbl[0] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};

    reset  = 1'b1;
    PushIn = 1'b0;
    SampI  = '0;
    SampQ  = '0;
    #2;
    chk("reset_stopin", StopIn, 0);
    chk("reset_mux_sel", mux_sel, 0);
    chk("reset_acc_valid", vld, 0);
    chk("reset_final_en", fin, 0);
    chk("reset_samp_zero", (samp == '0), 1);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Impulse from an idle, empty block.
    run_table(24'sh400000, 24'shC00000, 48'h0, 1'b1);
    repeat (4) tick();

    // Burst of 8 consecutive pushes: last two see StopIn and are dropped.
    fin_log.delete();
    stop_exp = 8'b0000_0011;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("burst%0d_stopin", i), StopIn, stop_exp[i]);
      PushIn = 1'b1;
      SampI  = DATA_W'(32'h100 + i);
      SampQ  = -DATA_W'(32'h100 + i);
      if (!StopIn) begin
        sb_q.push_back({SampI, SampQ});
        acc++;
      end
      tick();
    end
    PushIn = 1'b0;
    chk("burst_stopin_release", StopIn, 0);
    chk("burst_accepted", acc, 6);
    repeat (30) tick();
    chk("burst_final_count", fin_log.size(), 6);
    for (int i = 1; i < fin_log.size(); i++) begin
      chk($sformatf("burst_final_spacing%0d", i), fin_log[i] - fin_log[i-1], 3);
    end

    // Shift depth: 30 samples through the 29-tap line.
    for (int k = 1; k <= 30; k++) begin
      push1(DATA_W'(k), -DATA_W'(k));
    end
    repeat (20) tick();
    e24 = 24'sd30;
    chk("shift_samp0_I", samp[0].I, e24);
    e24 = 24'sd2;
    chk("shift_samp28_I", samp[TAPS-1].I, e24);
    e24 = -24'sd2;
    chk("shift_samp28_Q", samp[TAPS-1].Q, e24);
    e24 = 24'sd3;
    chk("shift_samp27_I", samp[TAPS-2].I, e24);
    any = 1'b0;
    for (int k = 0; k < TAPS; k++) begin
      if (samp[k].I == 24'sd1) any = 1'b1;
    end
    chk("shift_value1_gone", any, 0);

    // Reset during PASS1 with more samples queued.
    push1(24'sh111111, 24'sh222222);
    push1(24'sh333333, 24'sh444444);
    push1(24'sh555555, 24'sh666666);
    w = 0;
    while (mux_sel != 2'd1 && w < 20) begin
      tick();
      w++;
    end
    chk("reach_pass1", mux_sel, 1);
    reset = 1'b1;
    #1;
    chk("midreset_stopin", StopIn, 0);
    chk("midreset_mux_sel", mux_sel, 0);
    chk("midreset_acc_valid", vld, 0);
    chk("midreset_final_en", fin, 0);
    chk("midreset_samp_zero", (samp == '0), 1);
    tick();
    reset = 1'b0;
    any = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("post_reset_final%0d", k), fin, 0);
      if (mux_sel != 2'd0 || vld) any = 1'b1;
    end
    chk("post_reset_fifo_idle", any, 0);
    chk("post_reset_samp_zero", (samp == '0), 1);

    // Idle gap: push again 10 cycles after the previous PASS2.
    a_val = {24'sh123456, 24'sh654321};
    push1(24'sh123456, 24'sh654321);
    w = 0;
    while (mux_sel != 2'd2 && w < 20) begin
      tick();
      w++;
    end
    chk("reach_pass2", mux_sel, 2);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k >= 4) begin
        chk($sformatf("idle%0d_mux_sel", k), mux_sel, 0);
        chk($sformatf("idle%0d_acc_valid", k), vld, 0);
        chk($sformatf("idle%0d_final_en", k), fin, 0);
      end
    end
    run_table(24'sh0ABCDE, 24'shF54321, a_val, 1'b0);
    chk("idle_samp1_history", samp[1], a_val);

    repeat (20) tick();
    chk("sb_drained", sb_q.size(), 0);
    chk("final_exp_drained", fin_exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
